// File: rtl/booth_mult_seq_if.sv
// Handshake and operand/result bundle between the execute stage and booth_mult_seq.
interface booth_mult_seq_if #(
   parameter int unsigned WIDTH = 32
);
   logic             ctrl_MULT;
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             data_resultRDY;
   logic             busy;

   // Requester side: issues the start pulse and operands, consumes the result
   modport master (
      output ctrl_MULT,
      output data_operandA,
      output data_operandB,
      input  data_result,
      input  data_exception,
      input  data_resultRDY,
      input  busy
   );

   // Multiplier side
   modport slave (
      input  ctrl_MULT,
      input  data_operandA,
      input  data_operandB,
      output data_result,
      output data_exception,
      output data_resultRDY,
      output busy
   );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one add/subtract and one arithmetic
// shift per cycle, WIDTH steps, low word of the product plus signed-overflow flag.
// Optional macro MULT_ZERO_SKIP_EN: a zero operand on the start edge skips the
// iterations and completes with a one-cycle latency.
module booth_mult_seq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic              clock,
   input  logic              reset,
   booth_mult_seq_if.slave   io_mult
);

   // Product register layout: {upper WIDTH, lower WIDTH, Booth Q-1 bit}
   localparam int unsigned PW = 2 * WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [PW-1:0]      r_prod;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_result;
   logic               r_exc;
   logic               r_rdy;
   logic               r_busy;

   logic [WIDTH:0]     w_upper_x;
   logic [WIDTH:0]     w_mcand_x;
   logic [WIDTH:0]     w_sum;
   logic [PW-1:0]      w_step;
   logic               w_last;
   logic               w_exc;
   logic               w_zero_op;

   // One extra guard bit so that subtracting the most negative multiplicand cannot wrap
   assign w_upper_x = {r_prod[PW-1], r_prod[PW-1:WIDTH+1]};
   assign w_mcand_x = {r_mcand[WIDTH-1], r_mcand};

   // Booth recoding of (Q0, Q-1): 01 adds, 10 subtracts, 00/11 leave the partial product
   always_comb begin
      w_sum = w_upper_x;
      case (r_prod[1:0])
         2'b01:   w_sum = w_upper_x + w_mcand_x;
         2'b10:   w_sum = w_upper_x - w_mcand_x;
         default: w_sum = w_upper_x;
      endcase
   end

   // The guard bit becomes the new sign, which is the arithmetic right shift by one
   assign w_step = {w_sum, r_prod[WIDTH:1]};

   assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

   // Overflow when the upper WIDTH+1 bits of the 2*WIDTH product are not a pure sign extension
   assign w_exc = ~((&r_prod[PW-1:WIDTH]) | ~(|r_prod[PW-1:WIDTH]));

`ifdef MULT_ZERO_SKIP_EN
   assign w_zero_op = (io_mult.data_operandA == '0) || (io_mult.data_operandB == '0);
`else
   assign w_zero_op = 1'b0;
`endif

   // Control FSM, datapath registers and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_prod   <= '0;
         r_mcand  <= '0;
         r_result <= '0;
         r_exc    <= 1'b0;
         r_rdy    <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_rdy <= 1'b0;
         case (r_state)
            IDLE: begin
               r_busy <= 1'b0;
            end
            RUN: begin
               r_prod <= w_step;
               r_cnt  <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_rdy    <= 1'b1;
               r_result <= r_prod[WIDTH:1];
               r_exc    <= w_exc;
               r_state  <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase

         // A start pulse wins over whatever the FSM was doing; a pending DONE pulse still fires
         if (io_mult.ctrl_MULT) begin
            r_mcand <= io_mult.data_operandA;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            if (w_zero_op) begin
               r_prod  <= '0;
               r_state <= DONE;
            end else begin
               r_prod  <= {{WIDTH{1'b0}}, io_mult.data_operandB, 1'b0};
               r_state <= RUN;
            end
         end
      end
   end

   assign io_mult.data_result    = r_result;
   assign io_mult.data_exception = r_exc;
   assign io_mult.data_resultRDY = r_rdy;
   assign io_mult.busy           = r_busy;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed and random products against
// a plain-arithmetic reference, plus restart, restart-in-DONE and reset-abort cases.
module tb_booth_mult_seq;

   localparam int unsigned WIDTH = 32;
   localparam int          LAT   = WIDTH + 1;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   booth_mult_seq_if #(.WIDTH(WIDTH)) mif ();

   booth_mult_seq #(
      .WIDTH (WIDTH),
      .CNT_W (6)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .io_mult (mif)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Single comparison point for the whole bench
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: full signed product, low word, overflow when the low word does not represent it
   function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic signed [2*WIDTH-1:0] sa, sb, p, low_x;
      logic [WIDTH-1:0]          low;
      sa    = {{WIDTH{a[WIDTH-1]}}, a};
      sb    = {{WIDTH{b[WIDTH-1]}}, b};
      p     = sa * sb;
      low   = p[WIDTH-1:0];
      low_x = {{WIDTH{low[WIDTH-1]}}, low};
      return {(p != low_x), low};
   endfunction

   function automatic int exp_latency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef MULT_ZERO_SKIP_EN
      if (a == '0 || b == '0) return 1;
`endif
      return LAT;
   endfunction

   // Present operands with a start pulse; returns just after the start edge
   task automatic do_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      mif.ctrl_MULT     = 1'b1;
      mif.data_operandA = a;
      mif.data_operandB = b;
      @(posedge clock);
      #1;
      mif.ctrl_MULT     = 1'b0;
   endtask

   // Poll for the ready pulse while scrambling the operand inputs
   task automatic wait_rdy(output int lat, output logic [WIDTH-1:0] res, output logic exc);
      lat = -1;
      res = '0;
      exc = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clock);
         #1;
         if (mif.data_resultRDY) begin
            lat = c;
            res = mif.data_result;
            exc = mif.data_exception;
            break;
         end
         mif.data_operandA = $urandom;
         mif.data_operandB = $urandom;
      end
   endtask

   // One complete operation from the idle state, with pulse-width and busy checks
   task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH:0]   exp;
      int               lat;
      logic [WIDTH-1:0] res;
      logic             exc;
      exp = model(a, b);
      do_start(a, b);
      check({tag, "_busy"}, 64'(mif.busy), 64'(1));
      wait_rdy(lat, res, exc);
      check({tag, "_lat"}, 64'(lat), 64'(exp_latency(a, b)));
      check({tag, "_res"}, 64'(res), 64'(exp[WIDTH-1:0]));
      check({tag, "_exc"}, 64'(exc), 64'(exp[WIDTH]));
      @(posedge clock);
      #1;
      check({tag, "_rdy_drop"}, 64'(mif.data_resultRDY), 64'(0));
      check({tag, "_busy_drop"}, 64'(mif.busy), 64'(0));
   endtask

   logic [WIDTH-1:0] dir_a [8];
   logic [WIDTH-1:0] dir_b [8];

   initial begin
      logic [WIDTH-1:0] a, b, a2, b2;
      logic [WIDTH:0]   exp;
      int               lat;
      logic [WIDTH-1:0] res;
      logic             exc;
      logic             seen;

      dir_a = '{32'd3, 32'hFFFF_FFF9, 32'h7FFF_FFFF, 32'h0001_0000,
                32'h8000_0000, 32'h8000_0000, 32'd0, 32'h8000_0000};
      dir_b = '{32'd5, 32'd6, 32'd1, 32'h0001_0000,
                32'hFFFF_FFFF, 32'd1, 32'd123, 32'h8000_0000};

      reset             = 1'b1;
      mif.ctrl_MULT     = 1'b0;
      mif.data_operandA = '0;
      mif.data_operandB = '0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_result", 64'(mif.data_result), 64'(0));
      check("rst_exc", 64'(mif.data_exception), 64'(0));
      check("rst_rdy", 64'(mif.data_resultRDY), 64'(0));
      check("rst_busy", 64'(mif.busy), 64'(0));
      reset = 1'b0;
      @(posedge clock);
      #1;

      for (int i = 0; i < 8; i++) begin
         run_op($sformatf("dir%0d", i), dir_a[i], dir_b[i]);
      end

      for (int i = 0; i < 20; i++) begin
         case ($urandom_range(0, 3))
            0:       begin a = $urandom_range(0, 65535); b = $urandom_range(0, 65535); end
            1:       begin a = -$urandom_range(0, 40000); b = $urandom_range(0, 40000); end
            2:       begin a = $urandom; b = $urandom_range(0, 3) - 2; end
            default: begin a = $urandom; b = $urandom; end
         endcase
         run_op($sformatf("rnd%0d", i), a, b);
      end

      // Restart during RUN: the aborted operation must not produce a pulse
      do_start(32'd3, 32'd5);
      seen = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         @(posedge clock);
         #1;
         seen = seen | mif.data_resultRDY;
      end
      do_start(32'd4, 32'd4);
      wait_rdy(lat, res, exc);
      check("rst_run_no_old_pulse", 64'(seen), 64'(0));
      check("restart_lat", 64'(lat + 10), 64'(43));
      check("restart_res", 64'(res), 64'(16));
      check("restart_exc", 64'(exc), 64'(0));
      @(posedge clock);
      #1;

      // Restart in the DONE cycle: the old pulse still fires on the restart edge
      a  = $urandom;  b  = $urandom;
      a2 = $urandom | 32'd1;  b2 = $urandom_range(1, 1000);
      do_start(a, b);
      repeat (LAT - 1) @(posedge clock);
      #1;
      check("done_restart_pre_rdy", 64'(mif.data_resultRDY), 64'(0));
      exp = model(a, b);
      do_start(a2, b2);
      check("done_restart_old_rdy", 64'(mif.data_resultRDY), 64'(1));
      check("done_restart_old_res", 64'(mif.data_result), 64'(exp[WIDTH-1:0]));
      check("done_restart_old_exc", 64'(mif.data_exception), 64'(exp[WIDTH]));
      exp = model(a2, b2);
      wait_rdy(lat, res, exc);
      check("done_restart_new_lat", 64'(lat), 64'(LAT));
      check("done_restart_new_res", 64'(res), 64'(exp[WIDTH-1:0]));
      check("done_restart_new_exc", 64'(exc), 64'(exp[WIDTH]));
      @(posedge clock);
      #1;

      // Reset mid-operation clears everything and suppresses the pulse
      do_start(32'd3, 32'd5);
      repeat (11) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      check("midrst_result", 64'(mif.data_result), 64'(0));
      check("midrst_exc", 64'(mif.data_exception), 64'(0));
      check("midrst_rdy", 64'(mif.data_resultRDY), 64'(0));
      check("midrst_busy", 64'(mif.busy), 64'(0));
      seen = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clock);
         #1;
         seen = seen | mif.data_resultRDY;
      end
      check("midrst_no_pulse", 64'(seen), 64'(0));

      run_op("after_rst", 32'hFFFF_FFFD, 32'hFFFF_FFFB);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
